// File: rtl/tron_pkg.sv
// rtl/tron_pkg.sv - shared tron input constants: directions, PS/2 scan codes, receiver FSM states
package tron_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_direction_rx_if.sv
// rtl/ps2_direction_rx_if.sv - PS/2 pin and decoded-command bundle for the direction receiver
interface ps2_direction_rx_if;
  logic       Ps2Clk;
  logic       Ps2Data;
  logic [7:0] Scan_Code;
  logic       Scan_Valid;
  logic       Frame_Err;
  logic [1:0] P1_Dir;
  logic       P1_Dir_Valid;
  logic [1:0] P2_Dir;
  logic       P2_Dir_Valid;
  logic       Start_Key;

  // master: keyboard pins plus command consumer; slave: the receiver itself
  modport master (
    output Ps2Clk, Ps2Data,
    input  Scan_Code, Scan_Valid, Frame_Err, P1_Dir, P1_Dir_Valid,
    input  P2_Dir, P2_Dir_Valid, Start_Key
  );

  modport slave (
    input  Ps2Clk, Ps2Data,
    output Scan_Code, Scan_Valid, Frame_Err, P1_Dir, P1_Dir_Valid,
    output P2_Dir, P2_Dir_Valid, Start_Key
  );
endinterface

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - synchroniser, agreement filter and falling-edge detect for one PS/2 line
module ps2_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_raw,
  output logic line_sync,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  assign line_sync = sync_q[SYNC_STAGES-1];

  // The filtered level only flips after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], line_raw};
    filt_d = filt_q;
    cnt_d  = '0;
    if (line_sync != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = line_sync;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign fall = filt_q & ~filt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_direction_rx.sv
// rtl/ps2_direction_rx.sv - PS/2 frame receiver and WASD/arrow direction decoder for tron.
// Optional Space start-key decode is built when PS2_START_KEY_EN is defined.
module ps2_direction_rx
  import tron_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               Clk,
  input  logic               Reset,
  ps2_direction_rx_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_fall;
  logic clk_sync_unused;

  ps2_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_clk_filter (
    .clk       (Clk),
    .reset     (Reset),
    .line_raw  (bus.Ps2Clk),
    .line_sync (clk_sync_unused),
    .fall      (clk_fall)
  );

  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   data_bit;

  assign data_sync_d = {data_sync_q[SYNC_STAGES-2:0], bus.Ps2Data};
  assign data_bit    = data_sync_q[SYNC_STAGES-1];

  ps2_state_e  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        e0_q, e0_d;
  logic        f0_q, f0_d;
  logic [7:0]  scan_code_q, scan_code_d;
  logic        scan_valid_q, scan_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  p1_dir_q, p1_dir_d;
  logic        p1_valid_q, p1_valid_d;
  logic [1:0]  p2_dir_q, p2_dir_d;
  logic        p2_valid_q, p2_valid_d;
`ifdef PS2_START_KEY_EN
  logic        start_q, start_d;
`endif

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    tmo_d        = tmo_q;
    e0_d         = e0_q;
    f0_d         = f0_q;
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    p1_dir_d     = p1_dir_q;
    p1_valid_d   = 1'b0;
    p2_dir_d     = p2_dir_q;
    p2_valid_d   = 1'b0;
`ifdef PS2_START_KEY_EN
    start_d      = 1'b0;
`endif

    if (state_q != ST_IDLE) begin
      tmo_d = tmo_q + TW'(1);
    end

    if (clk_fall) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!data_bit) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parity_d = data_bit;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (data_bit && odd_parity_ok(shift_q, parity_q)) begin
            scan_code_d  = shift_q;
            scan_valid_d = 1'b1;
            if (shift_q == SC_E0) begin
              e0_d = 1'b1;
            end else if (shift_q == SC_F0) begin
              f0_d = 1'b1;
            end else begin
              e0_d = 1'b0;
              f0_d = 1'b0;
              // Break codes only clear the prefix state; steering reacts to make codes.
              if (!f0_q && !e0_q) begin
                case (shift_q)
                  SC_W:    begin p1_dir_d = DIR_UP;    p1_valid_d = 1'b1; end
                  SC_D:    begin p1_dir_d = DIR_RIGHT; p1_valid_d = 1'b1; end
                  SC_S:    begin p1_dir_d = DIR_DOWN;  p1_valid_d = 1'b1; end
                  SC_A:    begin p1_dir_d = DIR_LEFT;  p1_valid_d = 1'b1; end
`ifdef PS2_START_KEY_EN
                  SC_SPACE: start_d = 1'b1;
`endif
                  default: ;
                endcase
              end else if (!f0_q && e0_q) begin
                case (shift_q)
                  SC_UP:    begin p2_dir_d = DIR_UP;    p2_valid_d = 1'b1; end
                  SC_RIGHT: begin p2_dir_d = DIR_RIGHT; p2_valid_d = 1'b1; end
                  SC_DOWN:  begin p2_dir_d = DIR_DOWN;  p2_valid_d = 1'b1; end
                  SC_LEFT:  begin p2_dir_d = DIR_LEFT;  p2_valid_d = 1'b1; end
                  default: ;
                endcase
              end
            end
          end else begin
            frame_err_d = 1'b1;
            e0_d        = 1'b0;
            f0_d        = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      // A stalled keyboard abandons the frame silently, prefixes included.
      state_d = ST_IDLE;
      tmo_d   = '0;
      e0_d    = 1'b0;
      f0_d    = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      data_sync_q  <= '1;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      tmo_q        <= '0;
      e0_q         <= 1'b0;
      f0_q         <= 1'b0;
      scan_code_q  <= 8'h00;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      p1_dir_q     <= DIR_RIGHT;
      p1_valid_q   <= 1'b0;
      p2_dir_q     <= DIR_LEFT;
      p2_valid_q   <= 1'b0;
`ifdef PS2_START_KEY_EN
      start_q      <= 1'b0;
`endif
    end else begin
      data_sync_q  <= data_sync_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tmo_q        <= tmo_d;
      e0_q         <= e0_d;
      f0_q         <= f0_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
      p1_dir_q     <= p1_dir_d;
      p1_valid_q   <= p1_valid_d;
      p2_dir_q     <= p2_dir_d;
      p2_valid_q   <= p2_valid_d;
`ifdef PS2_START_KEY_EN
      start_q      <= start_d;
`endif
    end
  end

  assign bus.Scan_Code    = scan_code_q;
  assign bus.Scan_Valid   = scan_valid_q;
  assign bus.Frame_Err    = frame_err_q;
  assign bus.P1_Dir       = p1_dir_q;
  assign bus.P1_Dir_Valid = p1_valid_q;
  assign bus.P2_Dir       = p2_dir_q;
  assign bus.P2_Dir_Valid = p2_valid_q;
`ifdef PS2_START_KEY_EN
  assign bus.Start_Key    = start_q;
`else
  assign bus.Start_Key    = 1'b0;
`endif

endmodule
